// File: rtl/cvxif_arb_pkg.sv
// Shared types for the CV-X-IF / load-unit dcache port arbiter.
// Request payload fields are sized for the widest supported configuration; the arbiter casts to its own widths.
package cvxif_arb_pkg;

    localparam int unsigned NUM_PORTS  = 2;
    localparam int unsigned ARB_ADDR_W = 64;
    localparam int unsigned ARB_DATA_W = 64;
    localparam int unsigned ARB_BE_W   = ARB_DATA_W / 8;
    localparam int unsigned ARB_ID_W   = 8;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_BE_W-1:0]   be;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_ID_W-1:0]   id;
    } arb_port_req_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/cvxif_owner_fifo.sv
// One-bit owner FIFO: remembers which port issued each outstanding read, in issue order.
// Depth may be 1 or any power of two; pointers wrap explicitly so both cases share one path.
module cvxif_owner_fifo #(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                din,
    input  logic                pop,
    output logic                head,
    output logic                full,
    output logic                empty,
    output logic [CntWidth-1:0] count
);

    logic [Depth-1:0]    mem;
    logic [PtrWidth-1:0] wptr;
    logic [PtrWidth-1:0] rptr;
    logic [CntWidth-1:0] cnt;
    logic                do_push;
    logic                do_pop;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (cnt == CntWidth'(Depth));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rptr];
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem  <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= next_ptr(wptr);
            end
            if (do_pop) begin
                rptr <= next_ptr(rptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/cvxif_dcache_arbiter.sv
// Shares one dcache request port between the load unit (port 0) and the CV-X-IF coprocessor (port 1).
// Optional stall counters: define CVXIF_DCACHE_ARB_PERF_EN to add stall_cnt_o and perf_clr_i.
module cvxif_dcache_arbiter
    import cvxif_arb_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned IdWidth        = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          RoundRobin     = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [1:0]                   req_i,
    input  logic [1:0]                   we_i,
    input  logic [2*AddrWidth-1:0]       addr_i,
    input  logic [2*(DataWidth/8)-1:0]   be_i,
    input  logic [2*DataWidth-1:0]       wdata_i,
    input  logic [2*IdWidth-1:0]         id_i,
    output logic [1:0]                   gnt_o,
    output logic [1:0]                   rvalid_o,
    output logic [DataWidth-1:0]         rdata_o,
    output logic [IdWidth-1:0]           rid_o,
    output logic                         dc_req_o,
    output logic                         dc_we_o,
    output logic [AddrWidth-1:0]         dc_addr_o,
    output logic [DataWidth/8-1:0]       dc_be_o,
    output logic [DataWidth-1:0]         dc_wdata_o,
    output logic [IdWidth-1:0]           dc_id_o,
    input  logic                         dc_gnt_i,
    input  logic                         dc_rvalid_i,
    input  logic [DataWidth-1:0]         dc_rdata_i,
    input  logic [IdWidth-1:0]           dc_rid_i,
`ifdef CVXIF_DCACHE_ARB_PERF_EN
    input  logic                         perf_clr_i,
    output logic [2*16-1:0]              stall_cnt_o,
`endif
    output logic                         busy_o
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    arb_state_e           state_q, state_d;
    logic                 lock_port_q, lock_port_d;
    logic                 rr_q, rr_d;
    logic                 sel;
    logic                 dc_req;
    logic                 xfer;
    logic [NUM_PORTS-1:0] eligible;
    logic                 read_room;
    arb_port_req_t        port_req [NUM_PORTS];

    logic                 fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CntWidth-1:0]  fifo_count;
    logic                 pop;
    logic                 push;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_req[p]       = '0;
            port_req[p].we    = we_i[p];
            port_req[p].addr  = ARB_ADDR_W'(addr_i[p*AddrWidth +: AddrWidth]);
            port_req[p].be    = ARB_BE_W'(be_i[p*BeWidth +: BeWidth]);
            port_req[p].wdata = ARB_DATA_W'(wdata_i[p*DataWidth +: DataWidth]);
            port_req[p].id    = ARB_ID_W'(id_i[p*IdWidth +: IdWidth]);
        end
    end

    assign pop       = dc_rvalid_i & ~fifo_empty;
    assign read_room = ~fifo_full | pop;
    // Port 0 is killed by flush before it ever reaches the dcache; port 1 never is.
    assign eligible  = req_i & (we_i | {NUM_PORTS{read_room}}) & {1'b1, ~flush_i};

    always_comb begin
        state_d     = state_q;
        lock_port_d = lock_port_q;
        rr_d        = rr_q;
        sel         = 1'b0;
        dc_req      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    dc_req = 1'b1;
                    if (eligible == 2'b11) begin
                        sel = RoundRobin ? rr_q : 1'b0;
                    end else begin
                        sel = eligible[1];
                    end
                    if (!dc_gnt_i) begin
                        state_d     = LOCKED;
                        lock_port_d = sel;
                    end
                end
            end
            LOCKED: begin
                sel = lock_port_q;
                if (flush_i && (lock_port_q == 1'b0)) begin
                    state_d = IDLE;
                end else begin
                    dc_req = 1'b1;
                    if (dc_gnt_i) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (dc_req && dc_gnt_i) begin
            rr_d = other_port(sel);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lock_port_q <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_port_q <= lock_port_d;
            rr_q        <= rr_d;
        end
    end

    assign xfer  = dc_req & dc_gnt_i;
    assign push  = xfer & ~port_req[sel].we;
    assign gnt_o = xfer ? (sel ? 2'b10 : 2'b01) : 2'b00;

    // Payload is zeroed when idle so the dcache side sees a quiet bus.
    always_comb begin
        dc_req_o   = dc_req;
        dc_we_o    = 1'b0;
        dc_addr_o  = '0;
        dc_be_o    = '0;
        dc_wdata_o = '0;
        dc_id_o    = '0;
        if (dc_req) begin
            dc_we_o    = port_req[sel].we;
            dc_addr_o  = AddrWidth'(port_req[sel].addr);
            dc_be_o    = BeWidth'(port_req[sel].be);
            dc_wdata_o = DataWidth'(port_req[sel].wdata);
            dc_id_o    = IdWidth'(port_req[sel].id);
        end
    end

    cvxif_owner_fifo #(
        .Depth (MaxOutstanding)
    ) u_owner_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .din   (sel),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rvalid_o = {pop & fifo_head, pop & ~fifo_head};
    assign rdata_o  = dc_rdata_i;
    assign rid_o    = dc_rid_i;
    assign busy_o   = (state_q == LOCKED) | (fifo_count != '0);

`ifdef CVXIF_DCACHE_ARB_PERF_EN
    logic [15:0] stall_cnt_q [NUM_PORTS];

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!rst_ni || perf_clr_i) begin
                stall_cnt_q[p] <= '0;
            end else if (req_i[p] && !gnt_o[p] && (stall_cnt_q[p] != 16'hFFFF)) begin
                stall_cnt_q[p] <= stall_cnt_q[p] + 16'd1;
            end
        end
    end

    assign stall_cnt_o = {stall_cnt_q[1], stall_cnt_q[0]};
`endif

`ifndef SYNTHESIS
    rvalid_without_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dc_rvalid_i && fifo_empty))
        else $error("dc_rvalid_i with no outstanding read");
`endif

endmodule

// File: tb/tb_cvxif_dcache_arbiter.sv
// Directed bench for cvxif_dcache_arbiter: transfer and response scoreboards plus cycle checks.
// Stall-counter checks are built when CVXIF_DCACHE_ARB_PERF_EN is defined.
module tb_cvxif_dcache_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int BW = DW / 8;
    localparam logic [DW-1:0] WMASK = 32'hFFFF0000;

    typedef struct packed {
        logic [1:0]    gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [DW-1:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic [1:0]    rvalid;
        logic [IW-1:0] rid;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [1:0]      req;
    logic [1:0]      we;
    logic [2*AW-1:0] addr;
    logic [2*BW-1:0] be;
    logic [2*DW-1:0] wdata;
    logic [2*IW-1:0] id;
    logic [1:0]      gnt_o;
    logic [1:0]      rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic [IW-1:0]   rid_o;
    logic            dc_req_o;
    logic            dc_we_o;
    logic [AW-1:0]   dc_addr_o;
    logic [BW-1:0]   dc_be_o;
    logic [DW-1:0]   dc_wdata_o;
    logic [IW-1:0]   dc_id_o;
    logic            dc_gnt;
    logic            dc_rvalid;
    logic [DW-1:0]   dc_rdata;
    logic [IW-1:0]   dc_rid;
    logic            busy_o;
`ifdef CVXIF_DCACHE_ARB_PERF_EN
    logic            perf_clr;
    logic [31:0]     stall_cnt;
`endif

    xfer_t exp_xfer_q[$];
    rsp_t  exp_rsp_q[$];
    xfer_t ex;
    rsp_t  er;
    int    tests;
    int    fails;

    cvxif_dcache_arbiter #(
        .AddrWidth      (AW),
        .DataWidth      (DW),
        .IdWidth        (IW),
        .MaxOutstanding (2),
        .RoundRobin     (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .be_i        (be),
        .wdata_i     (wdata),
        .id_i        (id),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .rid_o       (rid_o),
        .dc_req_o    (dc_req_o),
        .dc_we_o     (dc_we_o),
        .dc_addr_o   (dc_addr_o),
        .dc_be_o     (dc_be_o),
        .dc_wdata_o  (dc_wdata_o),
        .dc_id_o     (dc_id_o),
        .dc_gnt_i    (dc_gnt),
        .dc_rvalid_i (dc_rvalid),
        .dc_rdata_i  (dc_rdata),
        .dc_rid_i    (dc_rid),
`ifdef CVXIF_DCACHE_ARB_PERF_EN
        .perf_clr_i  (perf_clr),
        .stall_cnt_o (stall_cnt),
`endif
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input logic r, input logic w,
                              input logic [AW-1:0] a, input logic [IW-1:0] i);
        req[p]             = r;
        we[p]              = w;
        addr[p*AW +: AW]   = a;
        id[p*IW +: IW]     = i;
        be[p*BW +: BW]     = r ? '1 : '0;
        wdata[p*DW +: DW]  = a ^ WMASK;
    endtask

    task automatic expect_xfer(input logic [1:0] g, input logic w,
                               input logic [AW-1:0] a, input logic [IW-1:0] i);
        xfer_t e;
        e.gnt   = g;
        e.we    = w;
        e.addr  = a;
        e.id    = i;
        e.wdata = a ^ WMASK;
        exp_xfer_q.push_back(e);
    endtask

    task automatic respond(input logic [1:0] to_port, input logic [IW-1:0] r, input logic [DW-1:0] d);
        rsp_t e;
        dc_rvalid = 1'b1;
        dc_rid    = r;
        dc_rdata  = d;
        e.rvalid  = to_port;
        e.rid     = r;
        e.rdata   = d;
        exp_rsp_q.push_back(e);
    endtask

    task automatic quiet_rsp();
        dc_rvalid = 1'b0;
        dc_rid    = '0;
        dc_rdata  = '0;
    endtask

    task automatic idle_all();
        req    = '0;
        we     = '0;
        addr   = '0;
        be     = '0;
        wdata  = '0;
        id     = '0;
        flush  = 1'b0;
        dc_gnt = 1'b0;
        quiet_rsp();
    endtask

    // Monitor: every accepted dcache transfer and every routed response is scored.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dc_req_o && dc_gnt) begin
                if (exp_xfer_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL xfer_unexpected: got addr %0h gnt %b, expected no transfer", dc_addr_o, gnt_o);
                end else begin
                    ex = exp_xfer_q.pop_front();
                    check("xfer_gnt", gnt_o, ex.gnt);
                    check("xfer_addr", dc_addr_o, ex.addr);
                    check("xfer_we", dc_we_o, ex.we);
                    check("xfer_id", dc_id_o, ex.id);
                    if (ex.we) check("xfer_wdata", dc_wdata_o, ex.wdata);
                end
            end
            if (rvalid_o != 2'b00) begin
                if (exp_rsp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got rvalid %b, expected none", rvalid_o);
                end else begin
                    er = exp_rsp_q.pop_front();
                    check("rsp_rvalid", rvalid_o, er.rvalid);
                    check("rsp_rid", rid_o, er.rid);
                    check("rsp_rdata", rdata_o, er.rdata);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle_all();
`ifdef CVXIF_DCACHE_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        repeat (3) cyc();
        check("rst_dc_req", dc_req_o, 1'b0);
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_rvalid", rvalid_o, 2'b00);
        rst_n = 1'b1;

        // Simultaneous reads: pointer starts on port 0.
        cyc();
        drive_port(0, 1'b1, 1'b0, 32'h100, 2'd1);
        drive_port(1, 1'b1, 1'b0, 32'h200, 2'd2);
        dc_gnt = 1'b1;
        expect_xfer(2'b01, 1'b0, 32'h100, 2'd1);
        expect_xfer(2'b10, 1'b0, 32'h200, 2'd2);
        #1 check("rr_first_gnt", gnt_o, 2'b01);
        cyc();
        drive_port(0, 1'b0, 1'b0, '0, '0);
        #1 check("rr_second_gnt", gnt_o, 2'b10);
        cyc();
        drive_port(1, 1'b0, 1'b0, '0, '0);
        dc_gnt = 1'b0;
        respond(2'b01, 2'd1, 32'hAAAA0001);
        #1 check("rr_busy_outstanding", busy_o, 1'b1);
        cyc();
        respond(2'b10, 2'd2, 32'hBBBB0002);
        cyc();
        quiet_rsp();
        #1 check("rr_drained_busy", busy_o, 1'b0);

        // Port 1 write locked for 3 cycles while port 0 waits.
        cyc();
        drive_port(1, 1'b1, 1'b1, 32'h300, 2'd3);
        #1 check("lock_req", dc_req_o, 1'b1);
        check("lock_addr0", dc_addr_o, 32'h300);
        cyc();
        drive_port(0, 1'b1, 1'b0, 32'h140, 2'd0);
        #1 check("lock_hold_addr1", dc_addr_o, 32'h300);
        check("lock_no_gnt", gnt_o, 2'b00);
        cyc();
        #1 check("lock_hold_addr2", dc_addr_o, 32'h300);
        check("lock_busy", busy_o, 1'b1);
        cyc();
        dc_gnt = 1'b1;
        expect_xfer(2'b10, 1'b1, 32'h300, 2'd3);
        #1 check("lock_release_gnt", gnt_o, 2'b10);
        cyc();
        drive_port(1, 1'b0, 1'b0, '0, '0);
        expect_xfer(2'b01, 1'b0, 32'h140, 2'd0);
        #1 check("lock_next_port0", gnt_o, 2'b01);
        cyc();
        drive_port(0, 1'b0, 1'b0, '0, '0);
        dc_gnt = 1'b0;
        respond(2'b01, 2'd0, 32'hCCCC0000);
        cyc();
        quiet_rsp();

        // Owner FIFO full: third read waits for the first response, then is granted with the pop.
        cyc();
        drive_port(0, 1'b1, 1'b0, 32'h400, 2'd0);
        dc_gnt = 1'b1;
        expect_xfer(2'b01, 1'b0, 32'h400, 2'd0);
        cyc();
        drive_port(0, 1'b1, 1'b0, 32'h404, 2'd1);
        expect_xfer(2'b01, 1'b0, 32'h404, 2'd1);
        cyc();
        drive_port(0, 1'b1, 1'b0, 32'h408, 2'd2);
        #1 check("full_no_req", dc_req_o, 1'b0);
        check("full_no_gnt", gnt_o, 2'b00);
        cyc();
        #1 check("full_still_no_req", dc_req_o, 1'b0);
        cyc();
        respond(2'b01, 2'd0, 32'hD0D0_0000);
        expect_xfer(2'b01, 1'b0, 32'h408, 2'd2);
        #1 check("full_pop_req", dc_req_o, 1'b1);
        check("full_pop_gnt", gnt_o, 2'b01);
        cyc();
        drive_port(0, 1'b0, 1'b0, '0, '0);
        dc_gnt = 1'b0;
        respond(2'b01, 2'd1, 32'hD0D0_0001);
        cyc();
        respond(2'b01, 2'd2, 32'hD0D0_0002);
        cyc();
        quiet_rsp();
        #1 check("full_drained", busy_o, 1'b0);

        // Pointer now on port 1: simultaneous writes go port 1 then port 0.
        cyc();
        drive_port(0, 1'b1, 1'b1, 32'h800, 2'd1);
        drive_port(1, 1'b1, 1'b1, 32'h804, 2'd2);
        dc_gnt = 1'b1;
        expect_xfer(2'b10, 1'b1, 32'h804, 2'd2);
        expect_xfer(2'b01, 1'b1, 32'h800, 2'd1);
        #1 check("rr_ptr_port1_wins", gnt_o, 2'b10);
        cyc();
        drive_port(1, 1'b0, 1'b0, '0, '0);
        #1 check("rr_then_port0", gnt_o, 2'b01);
        cyc();
        drive_port(0, 1'b0, 1'b0, '0, '0);
        dc_gnt = 1'b0;
        #1 check("writes_no_busy", busy_o, 1'b0);

        // Flush drops a port-0 lock but keeps its outstanding read; port 1 is immune.
        cyc();
        drive_port(0, 1'b1, 1'b0, 32'h500, 2'd1);
        dc_gnt = 1'b1;
        expect_xfer(2'b01, 1'b0, 32'h500, 2'd1);
        cyc();
        drive_port(0, 1'b1, 1'b0, 32'h504, 2'd2);
        dc_gnt = 1'b0;
        cyc();
        flush = 1'b1;
        #1 check("flush_drop_req", dc_req_o, 1'b0);
        check("flush_no_gnt", gnt_o, 2'b00);
        cyc();
        flush = 1'b0;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        #1 check("flush_idle_no_req", dc_req_o, 1'b0);
        check("flush_fifo_kept", busy_o, 1'b1);
        cyc();
        drive_port(1, 1'b1, 1'b1, 32'h600, 2'd3);
        cyc();
        flush = 1'b1;
        #1 check("flush_spares_port1_req", dc_req_o, 1'b1);
        check("flush_spares_port1_addr", dc_addr_o, 32'h600);
        cyc();
        flush = 1'b0;
        dc_gnt = 1'b1;
        expect_xfer(2'b10, 1'b1, 32'h600, 2'd3);
        cyc();
        drive_port(1, 1'b0, 1'b0, '0, '0);
        dc_gnt = 1'b0;
        respond(2'b01, 2'd1, 32'hE0E0_0001);
        cyc();
        quiet_rsp();
        #1 check("flush_rsp_drained", busy_o, 1'b0);

        // Reset while locked with one read outstanding.
        cyc();
        drive_port(0, 1'b1, 1'b0, 32'h700, 2'd1);
        dc_gnt = 1'b1;
        expect_xfer(2'b01, 1'b0, 32'h700, 2'd1);
        cyc();
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b1, 1'b0, 32'h704, 2'd2);
        dc_gnt = 1'b0;
        cyc();
        rst_n = 1'b0;
        idle_all();
        cyc();
        rst_n = 1'b1;
        #1 check("rst2_dc_req", dc_req_o, 1'b0);
        check("rst2_gnt", gnt_o, 2'b00);
        check("rst2_busy", busy_o, 1'b0);
        check("rst2_rvalid", rvalid_o, 2'b00);
        check("rst2_addr", dc_addr_o, 32'h0);
        check("rst2_id", dc_id_o, 2'd0);

`ifdef CVXIF_DCACHE_ARB_PERF_EN
        cyc();
        perf_clr = 1'b1;
        cyc();
        perf_clr = 1'b0;
        drive_port(1, 1'b1, 1'b1, 32'h900, 2'd1);
        repeat (5) cyc();
        dc_gnt = 1'b1;
        expect_xfer(2'b10, 1'b1, 32'h900, 2'd1);
        cyc();
        drive_port(1, 1'b0, 1'b0, '0, '0);
        dc_gnt = 1'b0;
        #1 check("perf_port1_stalls", stall_cnt[31:16], 16'd5);
        check("perf_port0_stalls", stall_cnt[15:0], 16'd0);
        perf_clr = 1'b1;
        cyc();
        perf_clr = 1'b0;
        #1 check("perf_cleared", stall_cnt, 32'd0);
`endif

        repeat (2) cyc();
        check("xfer_q_empty", exp_xfer_q.size(), 0);
        check("rsp_q_empty", exp_rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cvxif_dcache_arbiter.md
Name: cvxif_dcache_arbiter

Overview:
- Shares one dcache request port between two requesters: the core load path (port 0) and the CV-X-IF coprocessor memory interface (port 1).
- Sits between the coprocessor functional unit, the load unit and one dcache port.
- Arbitrates requests and holds the grant stable until the dcache accepts.
- Records the owner of each outstanding read so in-order read responses return to the requester that issued them.

Parameters:
- AddrWidth, 32, request address width (index+tag concatenated)
- DataWidth, 32, read/write data width (XLEN)
- IdWidth, 2, transaction id width carried with each request
- MaxOutstanding, 2, read responses in flight; depth of owner FIFO, power of 2, >=1
- RoundRobin, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_i  in  1  pipeline flush; kills port-0 requests not yet granted
- req_i  in  2  per-port request valid
- we_i  in  2  per-port write enable
- addr_i  in  2*AddrWidth  per-port address
- be_i  in  2*(DataWidth/8)  per-port byte enables
- wdata_i  in  2*DataWidth  per-port write data
- id_i  in  2*IdWidth  per-port transaction id
- gnt_o  out  2  per-port grant, one-hot or zero
- rvalid_o  out  2  per-port read response valid
- rdata_o  out  DataWidth  read data, broadcast to both ports
- rid_o  out  IdWidth  response id, broadcast to both ports
- dc_req_o  out  1  dcache request
- dc_we_o  out  1  dcache write enable
- dc_addr_o  out  AddrWidth  dcache address
- dc_be_o  out  DataWidth/8  dcache byte enables
- dc_wdata_o  out  DataWidth  dcache write data
- dc_id_o  out  IdWidth  dcache request id
- dc_gnt_i  in  1  dcache grant
- dc_rvalid_i  in  1  dcache read response valid
- dc_rdata_i  in  DataWidth  dcache read data
- dc_rid_i  in  IdWidth  dcache response id
- busy_o  out  1  owner FIFO not empty or grant locked

Behaviour:
- Reset, sampled on clk_i while rst_ni=0:
  - all outputs 0;
  - lock cleared;
  - owner FIFO emptied;
  - RR pointer = port 0.
- States:
  - IDLE: no lock. Eligible port chosen combinationally. dc_req_o asserted in the same cycle as req_i (0-cycle latency). Go to LOCKED if dc_gnt_i=0 in that cycle.
  - LOCKED: selected port held. The mux stays on the locked port even if the other port requests. Requester must hold req_i and its payload stable until gnt_o. Return to IDLE on dc_gnt_i.
- Eligibility:
  - A read request is eligible only if the owner FIFO is not full, or if a pop occurs in the same cycle.
  - A write is always eligible.
- gnt_o[p] = dc_gnt_i & (selected==p). No combinational path from dc_gnt_i to dc_req_o.
- Round-robin: after a granted transfer, the pointer moves to the other port. If both ports are eligible in IDLE, the pointer port wins.
- Read grant: push the owner port index into the FIFO. Writes push nothing.
- dc_rvalid_i: pop the FIFO head.
  - rvalid_o[head] = 1; rdata_o/rid_o pass through combinationally.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo MaxOutstanding.
- dc_rvalid_i with the FIFO empty is a protocol error: ignored, no rvalid_o. Trapped by an assertion in simulation.
- flush_i:
  - In LOCKED on port 0 without grant: drop the lock and go to IDLE.
  - dc_req_o is deasserted the same cycle.
  - The FIFO is untouched, because granted reads still return.
  - Port 1 (coprocessor) is never flushed.
- busy_o = lock | (count != 0).

Optional Feature:
- Macro: CVXIF_DCACHE_ARB_PERF_EN
- When defined, adds:
  - output stall_cnt_o[2*16]: per-port saturating 16-bit count of cycles with req_i high and gnt_o low;
  - input perf_clr_i: synchronous clear.
- Counters reset to 0 and saturate at 16'hFFFF.
- When not defined: no ports, no counter flops; behaviour otherwise identical.

Decomposition:
- Shared package cvxif_arb_pkg holds:
  - typedef arb_port_req_t (we, addr, be, wdata, id);
  - typedef arb_state_e {IDLE, LOCKED};
  - localparam NUM_PORTS = 2.
- Sub-module cvxif_owner_fifo: 1-bit-wide FIFO, depth MaxOutstanding, push/pop/full/empty/count, synchronous active-low reset.

Test Plan:
- Both ports read at addr 0x100/0x200 in the same cycle, dc_gnt_i=1, RoundRobin=1 -> port 0 granted in cycle 0, port 1 in cycle 1. Responses rid=1 then rid=2 -> rvalid_o=2'b01 then 2'b10.
- Port 1 write, dc_gnt_i held low 3 cycles while port 0 requests -> dc_addr_o stays on port 1, gnt_o=2'b10 in cycle 3, port 0 granted next.
- MaxOutstanding=2, port 0 issues 3 reads, no responses -> third read gets no dc_req_o until the first dc_rvalid_i. It is granted in the same cycle as that pop.
- Port 0 locked, flush_i=1 -> dc_req_o=0 the same cycle, state IDLE. A pending read response still routes to port 0.
- Assert rst_ni=0 for 1 cycle mid-LOCKED with 1 outstanding read -> next cycle all outputs 0, busy_o=0, FIFO empty.
- With CVXIF_DCACHE_ARB_PERF_EN defined, port 1 stalled 5 cycles -> stall_cnt_o[31:16]=5; perf_clr_i pulse -> 0.
